// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit full-duplex transfer per accepted start, LSB first.
// Define SPI_MASTER_MSB_FIRST_EN to transmit and receive MSB first instead.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } state_t;

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      tx_sr;
  logic [7:0]      rx_sr;
  logic            div_end;

  always_comb begin
    div_end = (div_cnt == DIV_LAST);
  end

  // mosi is taken straight from the end of the transmit shift register, which
  // is cleared on return to IDLE so the line idles low.
`ifdef SPI_MASTER_MSB_FIRST_EN
  assign mosi = tx_sr[7];
`else
  assign mosi = tx_sr[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      ss      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= tx_data;
            ss      <= 1'b0;
            busy    <= 1'b1;
          end
        end

        SETUP, LOW: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= HIGH;
            sclk    <= 1'b1;
`ifdef SPI_MASTER_MSB_FIRST_EN
            rx_sr   <= {rx_sr[6:0], miso};
`else
            rx_sr   <= {miso, rx_sr[7:1]};
`endif
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        HIGH: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            // The falling edge after the eighth bit goes straight to HOLD,
            // keeping the frame at 17 half-periods.
            if (bit_cnt == 3'd7) begin
              state <= HOLD;
            end else begin
              state   <= LOW;
              bit_cnt <= bit_cnt + 1'b1;
`ifdef SPI_MASTER_MSB_FIRST_EN
              tx_sr   <= {tx_sr[6:0], 1'b0};
`else
              tx_sr   <= {1'b0, tx_sr[7:1]};
`endif
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= IDLE;
            tx_sr   <= '0;
            ss      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a D=4 instance against a behavioural slave
// and a D=1 instance in loopback for back-to-back transfers.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  // Instance A: CLK_DIV = 4 with a behavioural slave on miso
  logic       start_a, busy_a, done_a, sclk_a, mosi_a, miso_a, ss_a;
  logic [7:0] tx_a, rx_a;

  spi_master #(.CLK_DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .rx_data(rx_a),
    .busy(busy_a), .done(done_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .ss(ss_a)
  );

  // Instance B: CLK_DIV = 1, miso looped back to mosi
  logic       start_b, busy_b, done_b, sclk_b, mosi_b, ss_b;
  logic [7:0] tx_b, rx_b;

  spi_master #(.CLK_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .rx_data(rx_b),
    .busy(busy_b), .done(done_b), .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b), .ss(ss_b)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Position in a byte of the i-th bit on the wire
  function automatic logic wire_bit(input logic [7:0] b, input int i);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return b[7-i];
`else
    return b[i];
`endif
  endfunction

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Behavioural mode-0 slave: first bit on ss fall, next bit on each sclk fall
  logic [7:0] slv_byte = 8'h00;
  int         slv_idx  = 0;
  initial miso_a = 1'b0;
  always @(negedge ss_a) begin
    slv_idx = 0;
    miso_a  = wire_bit(slv_byte, 0);
  end
  always @(negedge sclk_a) begin
    if (!ss_a) begin
      slv_idx++;
      if (slv_idx < 8) miso_a = wire_bit(slv_byte, slv_idx);
    end
  end

  // Monitor A
  int         t_a = 0;
  int         nrise_a = 0;
  logic [7:0] seen_a = '0;
  logic       pbusy_a = 1'b0, psclk_a = 1'b0, pmosi_a = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nrise_a = 0;
      pbusy_a = 1'b0;
      psclk_a = 1'b0;
      pmosi_a = 1'b0;
    end else begin
      if (busy_a && !pbusy_a) begin
        t_a     = cyc;
        nrise_a = 0;
        seen_a  = '0;
      end
      if (sclk_a && !psclk_a) begin
        check("sclk_rise_time", cyc - t_a, (2 * nrise_a + 1) * 4);
        check("mosi_setup_stable", mosi_a, pmosi_a);
        if (nrise_a < 8) seen_a[nrise_a] = mosi_a;
        nrise_a++;
      end else if (sclk_a && psclk_a) begin
        check("mosi_stable_while_high", mosi_a, pmosi_a);
      end
      if (done_a) begin
        check("done_time", cyc - t_a, 17 * 4);
        check("ss_high_at_done", ss_a, 1);
        check("busy_low_at_done", busy_a, 0);
        check("sclk_rise_count", nrise_a, 8);
        if (q_a.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done_a: got done with empty queue, rx=0x%0h at cycle %0d", rx_a, cyc);
        end else begin
          exp_t e;
          logic [7:0] exp_seq;
          e = q_a.pop_front();
          for (int i = 0; i < 8; i++) exp_seq[i] = wire_bit(e.tx, i);
          check("rx_data_a", rx_a, e.rx);
          check("mosi_sequence_a", seen_a, exp_seq);
        end
      end
      pbusy_a = busy_a;
      psclk_a = sclk_a;
      pmosi_a = mosi_a;
    end
  end

  // Monitor B: loopback data, done spacing and ss gap on back-to-back
  int   last_done_b = -1;
  int   hi_cnt_b = 0;
  logic pss_b = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_b) begin
        if (last_done_b >= 0) check("done_spacing_b", cyc - last_done_b, 18);
        last_done_b = cyc;
        hi_cnt_b    = 1;
        if (q_b.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done_b: got done with empty queue, rx=0x%0h at cycle %0d", rx_b, cyc);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          check("rx_data_b", rx_b, e.rx);
        end
      end else if (ss_b) begin
        hi_cnt_b++;
      end
      if (!ss_b && pss_b && last_done_b >= 0) check("ss_gap_b", hi_cnt_b, 1);
      pss_b = ss_b;
    end
  end

  task automatic wait_done_a(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_a) return;
    end
    checks++;
    fails++;
    $display("FAIL %s: got no done expected done within 200 cycles", nm);
  endtask

  task automatic wait_busy_b(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy_b) return;
    end
    checks++;
    fails++;
    $display("FAIL %s: got busy=0 expected busy=1 within 100 cycles", nm);
  endtask

  task automatic wait_done_b(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_b) return;
    end
    checks++;
    fails++;
    $display("FAIL %s: got no done expected done within 100 cycles", nm);
  endtask

  task automatic issue_a(input logic [7:0] tx, input logic [7:0] slv);
    exp_t e;
    e.tx = tx;
    e.rx = slv;
    q_a.push_back(e);
    slv_byte = slv;
    tx_a     = tx;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    tx_a    = '0;
    tx_b    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_ss", ss_a, 1);
    check("reset_sclk", sclk_a, 0);
    check("reset_mosi", mosi_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_rx", rx_a, 0);

    // Reference transfer
    issue_a(8'h0D, 8'h50);
    wait_done_a("done_0x0D");
    @(negedge clk);
    check("rx_held_after_done", rx_a, 8'h50);

    // start during a transfer must be ignored
    issue_a(8'h0D, 8'h96);
    repeat (19) @(negedge clk);
    tx_a     = 8'hFF;
    slv_byte = 8'h96;
    start_a  = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    check("busy_during_ignored_start", busy_a, 1);
    wait_done_a("done_ignored_start");
    repeat (80) @(negedge clk);

    // Asynchronous reset mid-transfer
    issue_a(8'h0D, 8'h3A);
    repeat (29) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ss", ss_a, 1);
    check("abort_sclk", sclk_a, 0);
    check("abort_mosi", mosi_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_rx", rx_a, 0);
    q_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_a(8'hC3, 8'h5A);
    wait_done_a("done_after_abort");
    @(negedge clk);

    // Randomized transfers
    for (int n = 0; n < 10; n++) begin
      issue_a(8'($urandom), 8'($urandom));
      wait_done_a("done_random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Back-to-back at D=1 with start held high
    begin
      exp_t e;
      e.tx = 8'hA5; e.rx = 8'hA5;
      q_b.push_back(e);
      tx_b    = 8'hA5;
      start_b = 1'b1;
      wait_busy_b("busy_b_first");
      e.tx = 8'h3C; e.rx = 8'h3C;
      q_b.push_back(e);
      tx_b = 8'h3C;
      wait_done_b("done_b_first");
      wait_busy_b("busy_b_second");
      start_b = 1'b0;
      wait_done_b("done_b_second");
      @(negedge clk);
      check("b_idle_busy", busy_b, 0);
      check("b_idle_ss", ss_b, 1);
    end

    repeat (5) @(negedge clk);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
